// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: STAGES slices of the writeback bundle with valid,
// stall/flush control, r0 write suppression and a saturating bubble counter.
module mem_wb_pipe #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned SEL_W  = 2,
   parameter int unsigned STAGES = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              MEM_valid,
   input  logic              MEM_RegWrite,
   input  logic [SEL_W-1:0]  MEM_MemtoReg,
   input  logic [REG_AW-1:0] MEM_Write_register,
   input  logic [XLEN-1:0]   MEM_ALU_out,
   input  logic [XLEN-1:0]   MEM_ReadData,
   input  logic [XLEN-1:0]   MEM_PC_plus_4,
   output logic              WB_valid,
   output logic              WB_RegWrite,
   output logic [SEL_W-1:0]  WB_MemtoReg,
   output logic [REG_AW-1:0] WB_Write_register,
   output logic [XLEN-1:0]   WB_ALU_out,
   output logic [XLEN-1:0]   WB_ReadData,
   output logic [XLEN-1:0]   WB_PC_plus_4,
   output logic [CNT_W-1:0]  bubble_count
);

   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("mem_wb_pipe: STAGES must be in 1..4");
   end

   localparam int unsigned LAST = STAGES - 1;

   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic [SEL_W-1:0]  memtoreg;
      logic [REG_AW-1:0] wreg;
      logic [XLEN-1:0]   alu;
      logic [XLEN-1:0]   rdata;
      logic [XLEN-1:0]   pc4;
   } slice_t;

   slice_t             r_sl    [STAGES];
   slice_t             w_chain [STAGES];
   slice_t             w_last;
   logic [CNT_W-1:0]   r_bubble;

   // w_chain[i] is what slice i captures on a normal cycle
   assign w_chain[0] = '{valid:    MEM_valid,
                         regwrite: MEM_RegWrite,
                         memtoreg: MEM_MemtoReg,
                         wreg:     MEM_Write_register,
                         alu:      MEM_ALU_out,
                         rdata:    MEM_ReadData,
                         pc4:      MEM_PC_plus_4};

   for (genvar g = 1; g < STAGES; g++) begin : g_chain
      assign w_chain[g] = r_sl[g-1];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < STAGES; i++) r_sl[i] <= '0;
      end else if (flush) begin
         // payload holds; only the valid bits are killed
         for (int unsigned i = 0; i < STAGES; i++) r_sl[i].valid <= 1'b0;
      end else if (!stall) begin
         for (int unsigned i = 0; i < STAGES; i++) r_sl[i] <= w_chain[i];
      end
   end

   assign w_last = r_sl[LAST];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bubble <= '0;
      end else if (!stall && !w_last.valid && (r_bubble != '1)) begin
         r_bubble <= r_bubble + 1'b1;
      end
   end

   assign WB_valid          = w_last.valid;
   assign WB_RegWrite       = w_last.regwrite & w_last.valid & (w_last.wreg != '0);
   assign WB_MemtoReg       = w_last.memtoreg;
   assign WB_Write_register = w_last.wreg;
   assign WB_ALU_out        = w_last.alu;
   assign WB_ReadData       = w_last.rdata;
   assign WB_PC_plus_4      = w_last.pc4;
   assign bubble_count      = r_bubble;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: three instances (STAGES=1/2/3) share one stimulus table;
// a per-instance queue holds the expected slice contents, front = WB output.
module tb_mem_wb_pipe;

   typedef struct packed {
      logic        stall;
      logic        flush;
      logic        v;
      logic        rw;
      logic [1:0]  m2r;
      logic [4:0]  wr;
      logic [31:0] alu;
      logic [31:0] rd;
      logic [31:0] pc;
      logic        gate;
   } vec_t;

   typedef struct packed {
      logic        v;
      logic        rw;
      logic [1:0]  m2r;
      logic [4:0]  wr;
      logic [31:0] alu;
      logic [31:0] rd;
      logic [31:0] pc;
      logic        gate;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, flush, mv, mrw;
   logic [1:0]  mm2r;
   logic [4:0]  mwr;
   logic [31:0] malu, mrd, mpc;

   logic        o_v   [3];
   logic        o_rw  [3];
   logic [1:0]  o_m2r [3];
   logic [4:0]  o_wr  [3];
   logic [31:0] o_alu [3];
   logic [31:0] o_rd  [3];
   logic [31:0] o_pc  [3];
   logic [15:0] o_bc  [3];
   logic [3:0]  bc1;

   int total = 0;
   int bad   = 0;

   ent_t        sb   [3][$];
   int unsigned cnt  [3];
   int unsigned maxc [3] = '{15, 65535, 65535};
   int unsigned stg  [3] = '{1, 2, 3};

   always #5 clk = ~clk;

   mem_wb_pipe #(.XLEN(32), .REG_AW(5), .SEL_W(2), .STAGES(1), .CNT_W(4)) u_d1 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .MEM_valid(mv), .MEM_RegWrite(mrw), .MEM_MemtoReg(mm2r), .MEM_Write_register(mwr),
      .MEM_ALU_out(malu), .MEM_ReadData(mrd), .MEM_PC_plus_4(mpc),
      .WB_valid(o_v[0]), .WB_RegWrite(o_rw[0]), .WB_MemtoReg(o_m2r[0]),
      .WB_Write_register(o_wr[0]), .WB_ALU_out(o_alu[0]), .WB_ReadData(o_rd[0]),
      .WB_PC_plus_4(o_pc[0]), .bubble_count(bc1));
   assign o_bc[0] = {12'd0, bc1};

   mem_wb_pipe #(.XLEN(32), .REG_AW(5), .SEL_W(2), .STAGES(2), .CNT_W(16)) u_d2 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .MEM_valid(mv), .MEM_RegWrite(mrw), .MEM_MemtoReg(mm2r), .MEM_Write_register(mwr),
      .MEM_ALU_out(malu), .MEM_ReadData(mrd), .MEM_PC_plus_4(mpc),
      .WB_valid(o_v[1]), .WB_RegWrite(o_rw[1]), .WB_MemtoReg(o_m2r[1]),
      .WB_Write_register(o_wr[1]), .WB_ALU_out(o_alu[1]), .WB_ReadData(o_rd[1]),
      .WB_PC_plus_4(o_pc[1]), .bubble_count(o_bc[1]));

   mem_wb_pipe #(.XLEN(32), .REG_AW(5), .SEL_W(2), .STAGES(3), .CNT_W(16)) u_d3 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .MEM_valid(mv), .MEM_RegWrite(mrw), .MEM_MemtoReg(mm2r), .MEM_Write_register(mwr),
      .MEM_ALU_out(malu), .MEM_ReadData(mrd), .MEM_PC_plus_4(mpc),
      .WB_valid(o_v[2]), .WB_RegWrite(o_rw[2]), .WB_MemtoReg(o_m2r[2]),
      .WB_Write_register(o_wr[2]), .WB_ALU_out(o_alu[2]), .WB_ReadData(o_rd[2]),
      .WB_PC_plus_4(o_pc[2]), .bubble_count(o_bc[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic s, input logic f, input logic v, input logic rw,
                               input logic [1:0] m2r, input logic [4:0] wr,
                               input logic [31:0] alu, input logic g);
      vec_t r;
      r.stall = s; r.flush = f; r.v = v; r.rw = rw; r.m2r = m2r; r.wr = wr;
      r.alu = alu; r.rd = alu ^ 32'hA5A5_0000; r.pc = alu + 32'h100; r.gate = g;
      return r;
   endfunction

   task automatic model_reset();
      ent_t z;
      z = '0;
      for (int i = 0; i < 3; i++) begin
         sb[i].delete();
         for (int unsigned s = 0; s < stg[i]; s++) sb[i].push_back(z);
         cnt[i] = 0;
      end
   endtask

   task automatic model_edge(input vec_t t);
      ent_t e;
      e.v = t.v; e.rw = t.rw; e.m2r = t.m2r; e.wr = t.wr;
      e.alu = t.alu; e.rd = t.rd; e.pc = t.pc; e.gate = t.gate;
      for (int i = 0; i < 3; i++) begin
         if (!t.stall && !sb[i][0].v && cnt[i] < maxc[i]) cnt[i]++;
         if (t.flush) begin
            for (int k = 0; k < sb[i].size(); k++) sb[i][k].v = 1'b0;
         end else if (!t.stall) begin
            sb[i].push_back(e);
            void'(sb[i].pop_front());
         end
      end
   endtask

   task automatic check_all(input string tag);
      ent_t e;
      for (int i = 0; i < 3; i++) begin
         e = sb[i][0];
         chk($sformatf("%s.d%0d.valid", tag, i), {31'd0, o_v[i]},   {31'd0, e.v});
         chk($sformatf("%s.d%0d.regw",  tag, i), {31'd0, o_rw[i]},  {31'd0, e.v & e.gate});
         chk($sformatf("%s.d%0d.m2r",   tag, i), {30'd0, o_m2r[i]}, {30'd0, e.m2r});
         chk($sformatf("%s.d%0d.wreg",  tag, i), {27'd0, o_wr[i]},  {27'd0, e.wr});
         chk($sformatf("%s.d%0d.alu",   tag, i), o_alu[i], e.alu);
         chk($sformatf("%s.d%0d.rdata", tag, i), o_rd[i],  e.rd);
         chk($sformatf("%s.d%0d.pc4",   tag, i), o_pc[i],  e.pc);
         chk($sformatf("%s.d%0d.bub",   tag, i), {16'd0, o_bc[i]}, cnt[i]);
      end
   endtask

   task automatic drive(input vec_t t);
      stall = t.stall; flush = t.flush; mv = t.v; mrw = t.rw; mm2r = t.m2r;
      mwr = t.wr; malu = t.alu; mrd = t.rd; mpc = t.pc;
   endtask

   task automatic step(input vec_t t, input string tag);
      drive(t);
      model_edge(t);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   vec_t tbl [19];
   vec_t idle;

   initial begin
      // stall flush v rw m2r wr alu gate
      tbl[0]  = mk(0, 0, 1, 1, 2'd0, 5'd5,  32'h1234, 1'b1);
      tbl[1]  = mk(0, 0, 1, 1, 2'd1, 5'd1,  32'd1,    1'b1);
      tbl[2]  = mk(0, 0, 1, 1, 2'd2, 5'd2,  32'd2,    1'b1);
      tbl[3]  = mk(0, 0, 1, 0, 2'd3, 5'd3,  32'd3,    1'b0);
      tbl[4]  = mk(0, 0, 1, 1, 2'd0, 5'd4,  32'd4,    1'b1);
      tbl[5]  = mk(1, 0, 1, 1, 2'd1, 5'd9,  32'h99,   1'b1);
      tbl[6]  = mk(1, 0, 0, 1, 2'd1, 5'd9,  32'h98,   1'b1);
      tbl[7]  = mk(0, 0, 1, 1, 2'd1, 5'd6,  32'd5,    1'b1);
      tbl[8]  = mk(0, 0, 0, 1, 2'd0, 5'd7,  32'h50,   1'b1);
      tbl[9]  = mk(0, 0, 1, 1, 2'd2, 5'd8,  32'd6,    1'b1);
      tbl[10] = mk(1, 1, 1, 1, 2'd3, 5'd10, 32'h77,   1'b1);
      tbl[11] = mk(0, 0, 1, 1, 2'd0, 5'd11, 32'd7,    1'b1);
      tbl[12] = mk(0, 0, 1, 1, 2'd1, 5'd0,  32'd8,    1'b0);
      tbl[13] = mk(0, 0, 1, 0, 2'd2, 5'd3,  32'd9,    1'b0);
      tbl[14] = mk(0, 1, 1, 1, 2'd0, 5'd12, 32'd10,   1'b1);
      tbl[15] = mk(0, 0, 1, 1, 2'd2, 5'd31, 32'd11,   1'b1);
      tbl[16] = mk(0, 0, 0, 0, 2'd0, 5'd0,  32'd0,    1'b0);
      tbl[17] = mk(0, 0, 0, 0, 2'd0, 5'd0,  32'd0,    1'b0);
      tbl[18] = mk(0, 0, 0, 0, 2'd0, 5'd0,  32'd0,    1'b0);
      idle    = mk(0, 0, 0, 0, 2'd0, 5'd0,  32'd0,    1'b0);

      reset = 1'b0;
      drive(idle);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("rst");
      reset = 1'b1;

      for (int n = 0; n < 19; n++) step(tbl[n], $sformatf("v%0d", n));

      for (int n = 0; n < 20; n++) step(idle, "idle");
      chk("sat.d0.bub", {16'd0, o_bc[0]}, 32'd15);

      step(tbl[1], "pre_arst");
      // reset lands between edges; outputs must clear without a clock
      #3;
      reset = 1'b0;
      model_reset();
      #1;
      check_all("arst");
      chk("arst.d2.bub0", {16'd0, o_bc[2]}, 32'd0);
      @(posedge clk);
      #1;
      check_all("arst_hold");
      reset = 1'b1;
      step(tbl[2], "post0");
      step(tbl[0], "post1");
      for (int n = 0; n < 3; n++) step(idle, "post_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
